line_tap_buffer: RTL and testbench
==================================

Name: line_tap_buffer

Overview:
Parametrised successor of the line-tap shift register used across the ISP pipeline. It buffers the last LINES image lines in cascaded single-clock RAMs and presents a vertical column of LINES+1 pixels per accepted input pixel. Neighbourhood stages (demosaic, denoise, sharpen) consume this column. The design adds:
- Valid-qualified advance.
- Runtime line width, latched per frame.
- Frame-start resynchronisation.
- Per-tap validity mask for top-border handling.
- Row/column position outputs.

Parameters:
BITS, 8, pixel width in bits
MAX_WIDTH, 1920, maximum line length in pixels (RAM depth)
LINES, 4, number of buffered lines (number of RAMs); column height is LINES+1
PTR_W, $clog2(MAX_WIDTH), derived column pointer width
WID_W, $clog2(MAX_WIDTH+1), derived width-config width

Ports:
clk  in  1  single clock
rst  in  1  synchronous, active-high reset
cfg_width_i  in  WID_W  active line width, latched at frame start
in_valid_i  in  1  input pixel qualifier
in_sof_i  in  1  first pixel of frame; only meaningful with in_valid_i
in_data_i  in  BITS  input pixel
out_valid_o  out  1  tap column valid
tap_data_o  out  BITS*(LINES+1)  slice k = pixel k lines above current (k=0 is current pixel)
tap_mask_o  out  LINES+1  bit k set when slice k belongs to the current frame
col_o  out  PTR_W  column of the output pixel
row_o  out  16  row of the output pixel (saturates at 65535)
line_end_o  out  1  pulses with the last pixel of each line

Behaviour:
- Clock and reset: one clock clk. Reset rst is synchronous and active-high.
- Reset values:
  - All outputs are 0.
  - Internal col = 0, row = 0.
  - Latched width = MAX_WIDTH.
  - RAM contents are not cleared.
- Width latch: the width is latched on each accepted pixel with in_sof_i=1.
  - cfg_width_i = 0 or > MAX_WIDTH → use MAX_WIDTH.
  - cfg_width_i = 1 → use 2. Minimum width is 2, which avoids a read/write address collision.
- Advance rule: state changes only on cycles where in_valid_i=1 (an accepted pixel). Idle cycles hold all state. out_valid_o=0 on the following cycle.
- SOF handling: an accepted pixel with in_sof_i=1 forces col=0 and row=0 for that pixel, regardless of the current position. A mid-line SOF therefore aborts the partial line.
- Column counter: col increments per accepted pixel. It wraps to 0 after col = width-1. On wrap, row increments (saturating).
- Read and cascade, for an accepted pixel at cycle t, column c:
  - All RAMs read address c at cycle t; data is available at t+1. RAMs are read-first.
  - At t+1, RAM 0 writes address c with the registered input pixel.
  - At t+1, RAM k (k≥1) writes address c with RAM k-1's read data.
- Output latency is 1 cycle. At t+1:
  - out_valid_o = 1.
  - Slice 0 = the pixel accepted at t.
  - Slice k = RAM k-1 read data.
  - col_o = c, row_o = row of that pixel.
  - line_end_o = (c == width-1).
- Mask: tap_mask_o[k] = (row ≥ k). Bit 0 is always 1 when out_valid_o=1. Slices with a clear mask bit are driven to 0, never stale data.
- Output gating: when out_valid_o=0, tap_data_o, tap_mask_o and line_end_o are 0. col_o and row_o hold their last values.
- Back-to-back pixels: the write to column c at t+1 and the read of c+1 at t+1 touch different addresses. Width ≥ 2 guarantees this, including across the wrap.
- Reset mid-frame: outputs are zeroed next cycle. The first pixel after reset is treated as row 0 even without SOF.

Decomposition:
- Shared ISP package holds:
  - Pixel-width default.
  - MAX_WIDTH default.
  - Clamp helper function for width config.
- One sub-module: line_tap_ram — simple dual-port, read-first, 1-cycle registered read, depth MAX_WIDTH, width BITS. It is instantiated LINES times in a generate loop.
- Top level holds:
  - Counters.
  - Width latch.
  - Write-address/data pipeline registers.
  - Mask and output registers.

Test Plan:
1. BITS=8, LINES=2, cfg_width=4, continuous valid, pixel = row*16+col, SOF on first pixel:
   - Row 0 outputs have mask=001, slices 1–2 = 0.
   - Row 2, col 1: taps = {0x01, 0x11, 0x21} (slice 2..0), mask=111.
   - line_end_o at col 3 every line.
2. Same stream with in_valid_i toggling 1,0,0,1:
   - Outputs are identical in value to test 1, shifted in time.
   - out_valid_o=0 during gaps; col_o/row_o hold.
3. SOF asserted at row 1, col 2 of frame A:
   - That pixel reports col_o=0, row_o=0, mask=001.
   - After two more full lines, mask=111.
4. cfg_width_i=0, then a frame with cfg_width_i=1:
   - Wrap occurs at col 1919, then at col 1.
   - No read/write collision; slice 1 equals the pixel exactly one line earlier.
5. rst pulsed mid-row 3:
   - Next cycle all outputs are 0.
   - The next valid pixel without SOF reports row 0, col 0, mask=001.
6. cfg_width_i changed mid-frame from 4 to 8 without SOF:
   - Wrap stays at 4 until the next SOF.
   - After SOF, wrap occurs at 8.

Source files
------------

// File: rtl/line_tap_buffer_pkg.sv
// Shared ISP definitions for the line-tap buffer.
// Holds pixel/line defaults and the width-config clamp.
package line_tap_buffer_pkg;

    localparam int unsigned PIX_BITS_DEF  = 8;
    localparam int unsigned MAX_WIDTH_DEF = 1920;
    localparam int unsigned MIN_WIDTH     = 2;
    localparam int unsigned ROW_W         = 16;

    // A zero or oversize request selects the full RAM depth. A width of
    // one is raised to two so a line never reads the column it writes.
    function automatic int unsigned clamp_width(
        input int unsigned cfg,
        input int unsigned max_w
    );
        int unsigned w;
        w = cfg;
        if (cfg == 0 || cfg > max_w) begin
            w = max_w;
        end else if (cfg < MIN_WIDTH) begin
            w = MIN_WIDTH;
        end
        return w;
    endfunction

endpackage

// File: rtl/line_tap_ram.sv
// Simple dual-port line RAM for the line-tap buffer.
// Read-first, one-cycle registered read, no reset on contents.
module line_tap_ram
    import line_tap_buffer_pkg::*;
#(
    parameter int unsigned BITS  = PIX_BITS_DEF,
    parameter int unsigned DEPTH = MAX_WIDTH_DEF,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [BITS-1:0] wdata_i,
    input  logic            re_i,
    input  logic [AW-1:0]   raddr_i,
    output logic [BITS-1:0] rdata_o
);

    logic [BITS-1:0] mem_q [DEPTH];
    logic [BITS-1:0] rdata_q;

    // Write port; old contents stay visible to a same-cycle read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; holds its value while no pixel is accepted.
    always_ff @(posedge clk) begin
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/line_tap_buffer.sv
// Cascaded line buffer presenting a LINES+1 pixel vertical column.
// Tracks frame position and masks taps above the top border.
module line_tap_buffer
    import line_tap_buffer_pkg::*;
#(
    parameter int unsigned BITS      = PIX_BITS_DEF,
    parameter int unsigned MAX_WIDTH = MAX_WIDTH_DEF,
    parameter int unsigned LINES     = 4,
    parameter int unsigned PTR_W     = $clog2(MAX_WIDTH),
    parameter int unsigned WID_W     = $clog2(MAX_WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WID_W-1:0]          cfg_width_i,
    input  logic                      in_valid_i,
    input  logic                      in_sof_i,
    input  logic [BITS-1:0]           in_data_i,
    output logic                      out_valid_o,
    output logic [BITS*(LINES+1)-1:0] tap_data_o,
    output logic [LINES:0]            tap_mask_o,
    output logic [PTR_W-1:0]          col_o,
    output logic [ROW_W-1:0]          row_o,
    output logic                      line_end_o
);

    // Frame position and latched width
    logic [PTR_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [WID_W-1:0] width_q, width_d;

    // Position of the pixel presented this cycle (SOF-adjusted)
    logic [PTR_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic [WID_W-1:0] cur_width;
    logic             last_col;
    logic [LINES:0]   mask_d;

    // Output-stage and RAM write pipeline
    logic             vld_q;
    logic [PTR_W-1:0] wr_addr_q;
    logic [BITS-1:0]  pix_q;
    logic [LINES:0]   mask_q;
    logic             le_q;
    logic [PTR_W-1:0] col_out_q;
    logic [ROW_W-1:0] row_out_q;

    logic [BITS-1:0]  rd_data [LINES];
    logic [BITS-1:0]  wr_data [LINES];

    // Resolve the incoming pixel's position; SOF restarts the frame
    // and picks up a freshly clamped width.
    always_comb begin
        cur_col   = col_q;
        cur_row   = row_q;
        cur_width = width_q;
        if (in_sof_i) begin
            cur_col   = '0;
            cur_row   = '0;
            cur_width = WID_W'(clamp_width(32'(cfg_width_i), MAX_WIDTH));
        end
        last_col = (WID_W'(cur_col) == cur_width - WID_W'(1));
    end

    // Advance column/row on accepted pixels only; row saturates.
    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        width_d = width_q;
        if (in_valid_i) begin
            width_d = cur_width;
            if (last_col) begin
                col_d = '0;
                row_d = (cur_row == '1) ? cur_row : cur_row + ROW_W'(1);
            end else begin
                col_d = cur_col + PTR_W'(1);
                row_d = cur_row;
            end
        end
    end

    // Tap k is in-frame once k lines of this frame have been seen.
    for (genvar k = 0; k <= LINES; k++) begin : g_mask
        assign mask_d[k] = (32'(cur_row) >= 32'(k));
    end

    // Position state, width latch and output-stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q     <= '0;
            row_q     <= '0;
            width_q   <= WID_W'(MAX_WIDTH);
            vld_q     <= 1'b0;
            wr_addr_q <= '0;
            pix_q     <= '0;
            mask_q    <= '0;
            le_q      <= 1'b0;
            col_out_q <= '0;
            row_out_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            width_q <= width_d;
            vld_q   <= in_valid_i;
            if (in_valid_i) begin
                wr_addr_q <= cur_col;
                pix_q     <= in_data_i;
                mask_q    <= mask_d;
                le_q      <= last_col;
                col_out_q <= cur_col;
                row_out_q <= cur_row;
            end
        end
    end

    // RAM g holds the line g+1 above; each one feeds the next on write.
    for (genvar g = 0; g < LINES; g++) begin : g_line
        if (g == 0) begin : g_head
            assign wr_data[g] = pix_q;
        end else begin : g_tail
            assign wr_data[g] = rd_data[g-1];
        end

        line_tap_ram #(
            .BITS  (BITS),
            .DEPTH (MAX_WIDTH),
            .AW    (PTR_W)
        ) u_ram (
            .clk     (clk),
            .we_i    (vld_q),
            .waddr_i (wr_addr_q),
            .wdata_i (wr_data[g]),
            .re_i    (in_valid_i),
            .raddr_i (cur_col),
            .rdata_o (rd_data[g])
        );
    end

    // Column slices, zeroed when idle or above the frame top.
    for (genvar k = 0; k <= LINES; k++) begin : g_tap
        logic [BITS-1:0] src;
        if (k == 0) begin : g_cur
            assign src = pix_q;
        end else begin : g_old
            assign src = rd_data[k-1];
        end
        assign tap_data_o[k*BITS +: BITS] = (vld_q && mask_q[k]) ? src : '0;
    end

    assign out_valid_o = vld_q;
    assign tap_mask_o  = vld_q ? mask_q : '0;
    assign line_end_o  = vld_q & le_q;
    assign col_o       = col_out_q;
    assign row_o       = row_out_q;

endmodule

// File: tb/tb_line_tap_buffer.sv
// Self-checking bench for line_tap_buffer (BITS=8, LINES=2).
// Reference model stores the frame as a (row,col) image.
module tb_line_tap_buffer;

    localparam int BITS  = 8;
    localparam int MAXW  = 1920;
    localparam int LINES = 2;
    localparam int PTR_W = 11;
    localparam int WID_W = 11;
    localparam int TW    = BITS * (LINES + 1);
    localparam int VW    = 1 + TW + (LINES + 1) + PTR_W + 16 + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WID_W-1:0] cfg_width_i = '0;
    logic             in_valid_i = 1'b0;
    logic             in_sof_i = 1'b0;
    logic [BITS-1:0]  in_data_i = '0;
    logic             out_valid_o;
    logic [TW-1:0]    tap_data_o;
    logic [LINES:0]   tap_mask_o;
    logic [PTR_W-1:0] col_o;
    logic [15:0]      row_o;
    logic             line_end_o;

    line_tap_buffer #(
        .BITS      (BITS),
        .MAX_WIDTH (MAXW),
        .LINES     (LINES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_width_i (cfg_width_i),
        .in_valid_i  (in_valid_i),
        .in_sof_i    (in_sof_i),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .tap_data_o  (tap_data_o),
        .tap_mask_o  (tap_mask_o),
        .col_o       (col_o),
        .row_o       (row_o),
        .line_end_o  (line_end_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: frame position and the image seen so far
    int             m_col;
    int             m_row;
    int             m_width;
    logic [BITS-1:0] img [int];

    logic             e_valid;
    logic [TW-1:0]    e_tap;
    logic [LINES:0]   e_mask;
    logic [PTR_W-1:0] e_col;
    logic [15:0]      e_row;
    logic             e_le;

    function automatic logic [VW-1:0] got_vec();
        return {out_valid_o, tap_data_o, tap_mask_o, col_o, row_o, line_end_o};
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {e_valid, e_tap, e_mask, e_col, e_row, e_le};
    endfunction

    function automatic int ref_width(input int cfg);
        if (cfg == 0 || cfg > MAXW) return MAXW;
        if (cfg == 1) return 2;
        return cfg;
    endfunction

    task automatic model_reset();
        m_col   = 0;
        m_row   = 0;
        m_width = MAXW;
        img.delete();
        e_valid = 1'b0;
        e_tap   = '0;
        e_mask  = '0;
        e_col   = '0;
        e_row   = '0;
        e_le    = 1'b0;
    endtask

    task automatic model_accept(input bit v, input bit s,
                                input logic [BITS-1:0] d, input int cfg);
        if (!v) begin
            e_valid = 1'b0;
            e_tap   = '0;
            e_mask  = '0;
            e_le    = 1'b0;
        end else begin
            if (s) begin
                m_col   = 0;
                m_row   = 0;
                m_width = ref_width(cfg);
                img.delete();
            end
            e_valid = 1'b1;
            e_col   = PTR_W'(m_col);
            e_row   = 16'(m_row);
            e_le    = (m_col == m_width - 1);
            e_tap   = '0;
            e_mask  = '0;
            for (int k = 0; k <= LINES; k++) begin
                if (m_row >= k) begin
                    e_mask[k] = 1'b1;
                    if (k == 0) e_tap[k*BITS +: BITS] = d;
                    else e_tap[k*BITS +: BITS] = img[(m_row - k) * 4096 + m_col];
                end
            end
            img[m_row * 4096 + m_col] = d;
            if (m_col == m_width - 1) begin
                m_col = 0;
                if (m_row < 65535) m_row++;
            end else begin
                m_col++;
            end
        end
    endtask

    // One clock: drive, let the edge take it, sample 1 ns later
    task automatic step(input bit v, input bit s, input logic [BITS-1:0] d);
        in_valid_i = v;
        in_sof_i   = s;
        in_data_i  = d;
        @(posedge clk);
        #1;
        model_accept(v, s, d, int'(cfg_width_i));
        in_valid_i = 1'b0;
        in_sof_i   = 1'b0;
    endtask

    task automatic do_reset(input bit v);
        rst        = 1'b1;
        in_valid_i = v;
        in_sof_i   = 1'b0;
        in_data_i  = 8'($urandom);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        in_valid_i = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cfg_width_i = 11'd4;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL reset: got=%h exp=%h", got_vec(), exp_vec());
        end
    endtask

    task automatic test_basic();
        cfg_width_i = 11'd4;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                checks++;
                if (got_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL basic r%0d c%0d: got=%h exp=%h",
                             r, c, got_vec(), exp_vec());
                end
                if (r == 0) begin
                    checks++;
                    if (tap_mask_o !== 3'b001 || tap_data_o[23:8] !== 16'h0) begin
                        errors++;
                        $display("FAIL basic_row0 c%0d: mask=%b taps=%h exp mask=001 upper=0",
                                 c, tap_mask_o, tap_data_o);
                    end
                end
                if (r == 2 && c == 1) begin
                    checks++;
                    if (tap_data_o !== 24'h011121 || tap_mask_o !== 3'b111) begin
                        errors++;
                        $display("FAIL basic_r2c1: taps=%h mask=%b exp taps=011121 mask=111",
                                 tap_data_o, tap_mask_o);
                    end
                end
                if (c == 3) begin
                    checks++;
                    if (line_end_o !== 1'b1) begin
                        errors++;
                        $display("FAIL basic_line_end r%0d: got=%b exp=1", r, line_end_o);
                    end
                end
            end
        end
    endtask

    task automatic test_gaps();
        cfg_width_i = 11'd4;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'b1, (r == 0 && c == 0), 8'(r * 16 + c));
                checks++;
                if (got_vec() !== exp_vec()) begin
                    errors++;
                    $display("FAIL gaps r%0d c%0d: got=%h exp=%h",
                             r, c, got_vec(), exp_vec());
                end
                if (r == 2 && c == 1) begin
                    checks++;
                    if (tap_data_o !== 24'h011121) begin
                        errors++;
                        $display("FAIL gaps_r2c1: taps=%h exp=011121", tap_data_o);
                    end
                end
                for (int g = 0; g < 2; g++) begin
                    step(1'b0, 1'b0, 8'($urandom));
                    checks++;
                    if (got_vec() !== exp_vec()) begin
                        errors++;
                        $display("FAIL gaps_idle r%0d c%0d: got=%h exp=%h",
                                 r, c, got_vec(), exp_vec());
                    end
                end
            end
        end
    endtask

    task automatic test_mid_sof();
        cfg_width_i = 11'd4;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, (i == 0), 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_sof_pre i%0d: got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        step(1'b1, 1'b1, 8'($urandom));
        checks++;
        if (col_o !== 11'd0 || row_o !== 16'd0 || tap_mask_o !== 3'b001) begin
            errors++;
            $display("FAIL mid_sof_restart: col=%0d row=%0d mask=%b exp 0 0 001",
                     col_o, row_o, tap_mask_o);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL mid_sof_post i%0d: got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        checks++;
        if (tap_mask_o !== 3'b111 || row_o !== 16'd2) begin
            errors++;
            $display("FAIL mid_sof_full_mask: mask=%b row=%0d exp 111 2", tap_mask_o, row_o);
        end
    endtask

    task automatic test_width_clamp();
        logic [BITS-1:0] hist [$];
        logic [BITS-1:0] d;
        cfg_width_i = 11'd0;
        for (int i = 0; i < 2 * MAXW + 4; i++) begin
            d = 8'($urandom);
            hist.push_back(d);
            step(1'b1, (i == 0), d);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clamp0 i%0d: got=%h exp=%h", i, got_vec(), exp_vec());
            end
            if (i == MAXW - 1 || i == 2 * MAXW - 1) begin
                checks++;
                if (col_o !== 11'd1919 || line_end_o !== 1'b1) begin
                    errors++;
                    $display("FAIL clamp0_wrap i%0d: col=%0d le=%b exp 1919 1",
                             i, col_o, line_end_o);
                end
            end
            if (i == MAXW + 5) begin
                checks++;
                if (tap_data_o[15:8] !== hist[i - MAXW]) begin
                    errors++;
                    $display("FAIL clamp0_slice1: got=%h exp=%h",
                             tap_data_o[15:8], hist[i - MAXW]);
                end
            end
        end
        hist.delete();
        cfg_width_i = 11'd1;
        for (int i = 0; i < 10; i++) begin
            d = 8'($urandom);
            hist.push_back(d);
            step(1'b1, (i == 0), d);
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL clamp1 i%0d: got=%h exp=%h", i, got_vec(), exp_vec());
            end
            checks++;
            if (line_end_o !== 1'((i % 2) == 1)) begin
                errors++;
                $display("FAIL clamp1_wrap i%0d: le=%b exp=%0d", i, line_end_o, i % 2);
            end
            if (i >= 2) begin
                checks++;
                if (tap_data_o[15:8] !== hist[i - 2]) begin
                    errors++;
                    $display("FAIL clamp1_slice1 i%0d: got=%h exp=%h",
                             i, tap_data_o[15:8], hist[i - 2]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        cfg_width_i = 11'd4;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, (i == 0), 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_mid_pre i%0d: got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
        do_reset(1'b1);
        checks++;
        if (got_vec() !== exp_vec() || got_vec() !== '0) begin
            errors++;
            $display("FAIL rst_mid_zero: got=%h exp=0", got_vec());
        end
        step(1'b1, 1'b0, 8'($urandom));
        checks++;
        if (col_o !== 11'd0 || row_o !== 16'd0 || tap_mask_o !== 3'b001) begin
            errors++;
            $display("FAIL rst_mid_first: col=%0d row=%0d mask=%b exp 0 0 001",
                     col_o, row_o, tap_mask_o);
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rst_mid_post i%0d: got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_width_change();
        cfg_width_i = 11'd4;
        for (int i = 0; i < 12; i++) begin
            if (i == 6) cfg_width_i = 11'd8;
            step(1'b1, (i == 0), 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wchg_old i%0d: got=%h exp=%h", i, got_vec(), exp_vec());
            end
            checks++;
            if (line_end_o !== 1'((i % 4) == 3)) begin
                errors++;
                $display("FAIL wchg_old_wrap i%0d: le=%b", i, line_end_o);
            end
        end
        for (int i = 0; i < 18; i++) begin
            step(1'b1, (i == 0), 8'($urandom));
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wchg_new i%0d: got=%h exp=%h", i, got_vec(), exp_vec());
            end
            checks++;
            if (line_end_o !== 1'((i % 8) == 7)) begin
                errors++;
                $display("FAIL wchg_new_wrap i%0d: le=%b", i, line_end_o);
            end
        end
    endtask

    task automatic test_random();
        int  opts [7] = '{0, 1, 2, 3, 5, 7, 2047};
        bit  v;
        bit  s;
        cfg_width_i = 11'd3;
        step(1'b1, 1'b1, 8'($urandom));
        checks++;
        if (got_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rand_start: got=%h exp=%h", got_vec(), exp_vec());
        end
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 40) == 0) cfg_width_i = 11'(opts[$urandom_range(0, 6)]);
            if ($urandom_range(0, 250) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                v = ($urandom_range(0, 3) != 0);
                s = v && ($urandom_range(0, 50) == 0);
                step(v, s, 8'($urandom));
            end
            checks++;
            if (got_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand i%0d: got=%h exp=%h", i, got_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_gaps();
        test_mid_sof();
        test_width_clamp();
        test_reset_mid();
        test_width_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
